seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed seven-segment scan controller for the Nexys-class 4-digit display. It consumes the one-cycle display tick and the blink level produced by the shared clock divider. It steps the anodes through each digit with a guard-blank interval between digits to suppress ghosting. New display values are committed only at frame boundaries so a scan never shows a torn value.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- BLANK_CYCLES, 16: master_clk cycles with all anodes off between digits; legal range 1..255.
- master_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- scan_tick  in  1  one-cycle display-rate pulse from the clock divider.
- blink  in  1  blink level from the clock divider; 1 = blank phase.
- update_req  in  1  one-cycle request to capture digit_vals, blink_mask and dp_in.
- digit_vals  in  4*NUM_DIGITS  hex nibble per digit; digit i at [4i+3:4i].
- blink_mask  in  NUM_DIGITS  1 = digit i blanks while blink=1.
- dp_in  in  NUM_DIGITS  1 = decimal point i lit.
- update_ack  out  1  one-cycle pulse when a pending capture is committed.
- an  out  NUM_DIGITS  anodes, active-low.
- seg  out  7  segments, active-low; seg[0]=a through seg[6]=g.
- dp  out  1  decimal point, active-low.

## Operation
- Two states:
  - SHOW: anode idx is driven.
  - BLANK: all anodes are off while a down-counter runs.
- Reset:
  - State BLANK, idx=NUM_DIGITS-1, counter=BLANK_CYCLES-1, pending=0.
  - Active and shadow registers are 0.
  - Outputs: an all 1s, seg=7'b1111111, dp=1, update_ack=0.
- SHOW + scan_tick: go to BLANK with counter=BLANK_CYCLES-1.
- BLANK with counter>0: decrement the counter. Any scan_tick is dropped, not queued.
- BLANK with counter=0: idx <= (idx+1) mod NUM_DIGITS, then go to SHOW.
  - If idx was NUM_DIGITS-1 (frame boundary) and pending=1: copy shadow into active, pulse update_ack.
- update_req: capture inputs into shadow; pending <= update_req | (pending & ~commit).
  - If update_req and commit coincide, the commit uses the previous shadow value. The new capture stays pending for the next frame.
  - Back-to-back requests overwrite the shadow; only the latest is committed, with one ack.
- SHOW outputs:
  - an[idx]=0 and all other anodes 1.
  - seg=decode(active nibble idx); dp=~active_dp[idx].
  - If blink=1 and active_mask[idx]=1, an is all 1s. The digit slot is still consumed.
- Decode (hex 0-F): 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110. Remaining codes follow the standard hex glyphs.
- rst mid-scan: on the next edge, return to the reset state and drop pending.

## Timing
- an, seg, dp and update_ack are registered. They take their new values on the same edge as the state transition.
- scan_tick high in cycle t: an is all 1s from edge t+1.
  - Next digit is driven from edge t+1+BLANK_CYCLES.
- After rst deasserts: digit 0 is driven BLANK_CYCLES cycles later.
- blink or mask changes reach an within 1 cycle.
- update_ack is high for exactly the first cycle of SHOW for digit 0 of the committing frame.
- idx width is clog2(NUM_DIGITS). The counter is 8 bits and never underflows.

## Structure
- Package seg_pkg holds:
  - the state enum (SHOW, BLANK);
  - the hex-to-segment constant array;
  - ANODE_OFF and SEG_OFF constants.
- Sub-module seg_decoder: combinational 4-bit -> 7-bit active-low decode, instantiated once on the muxed nibble.

## Test plan
- Reset then no ticks, BLANK_CYCLES=16 -> an=4'b1110 from cycle 16; seg=7'b1000000 (active=0); update_ack stays 0.
- update_req with digit_vals=16'hF810, then 5 scan_ticks -> update_ack pulses once at the next frame boundary. Then:
  - an sequence 1110/1101/1011/0111.
  - seg sequence 1000000 / 1111001 / 0000000 / 0001110.
  - Each digit is preceded by 16 cycles of an=1111.
- scan_tick during BLANK -> ignored; BLANK length is unchanged at 16.
- blink=1, blink_mask=4'b0100 -> an stays 1111 during digit 2's slot; other digits are unaffected; restored 1 cycle after blink=0.
- update_req in the commit cycle, then again mid-frame -> first ack commits the old shadow; the next frame commits only the latest values with one ack.
- rst mid-SHOW with pending=1 -> next edge gives an=1111 and seg=1111111; the pending capture is never acked.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: FSM encoding,
// active-low hex glyph table and the all-off output patterns.
package seg_pkg;

  localparam logic [0:0] S_SHOW  = 1'b0;
  localparam logic [0:0] S_BLANK = 1'b1;

  typedef enum logic [0:0] {
    SHOW  = S_SHOW,
    BLANK = S_BLANK
  } seg_state_e;

  // Wide enough for the largest legal digit count; slice to NUM_DIGITS.
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
import seg_pkg::*;

module seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with guard-blank intervals
// between digits and frame-boundary commit of new display values.
import seg_pkg::*;

module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic                    blink,
  input  logic                    update_req,
  input  logic [4*NUM_DIGITS-1:0] digit_vals,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    update_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output seg_state_e              dbg_state
);

  localparam int              IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       CNT_LOAD = 8'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  seg_state_e                state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [7:0]                cnt, cnt_nxt;
  logic                      pending;
  logic                      commit;

  logic [4*NUM_DIGITS-1:0]   act_vals, shd_vals, act_vals_nxt;
  logic [NUM_DIGITS-1:0]     act_mask, shd_mask, act_mask_nxt;
  logic [NUM_DIGITS-1:0]     act_dp, shd_dp, act_dp_nxt;

  logic [3:0]                nib;
  logic [6:0]                seg_dec;
  logic [NUM_DIGITS-1:0]     an_show;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      SHOW: begin
        if (scan_tick) begin
          state_nxt = BLANK;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BLANK: begin
        // Ticks arriving while blanking are dropped; the guard length is fixed.
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          state_nxt = SHOW;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          commit    = (idx == IDX_LAST) && pending;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Outputs are registered from next-state values so they change on the
  // same edge as the FSM and already reflect a freshly committed frame.
  assign act_vals_nxt = commit ? shd_vals : act_vals;
  assign act_mask_nxt = commit ? shd_mask : act_mask;
  assign act_dp_nxt   = commit ? shd_dp   : act_dp;
  assign nib          = act_vals_nxt[{idx_nxt, 2'b00} +: 4];
  assign an_show      = ~(NUM_DIGITS'(1) << idx_nxt);

  seg_decoder u_dec (
    .nibble (nib),
    .seg    (seg_dec)
  );

  always_ff @(posedge master_clk) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= IDX_LAST;
      cnt        <= CNT_LOAD;
      pending    <= 1'b0;
      act_vals   <= '0;
      act_mask   <= '0;
      act_dp     <= '0;
      shd_vals   <= '0;
      shd_mask   <= '0;
      shd_dp     <= '0;
      update_ack <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      act_vals <= act_vals_nxt;
      act_mask <= act_mask_nxt;
      act_dp   <= act_dp_nxt;
      if (update_req) begin
        shd_vals <= digit_vals;
        shd_mask <= blink_mask;
        shd_dp   <= dp_in;
      end
      // A request coinciding with a commit stays pending for the next frame.
      pending    <= update_req | (pending & ~commit);
      update_ack <= commit;
      if (state_nxt == SHOW) begin
        an  <= (blink && act_mask_nxt[idx_nxt]) ? AN_OFF : an_show;
        seg <= seg_dec;
        dp  <= ~act_dp_nxt[idx_nxt];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule
